// File: rtl/dem_controller.sv
// Run-control sequencer for an external W-bit counter: loads a start value, issues
// prescaled count-enable pulses, stops (one-shot) or reloads (continuous) at terminal count.
module dem_controller #(
  parameter int W     = 4,
  parameter int PRESC = 4,
  parameter int PW    = 16
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         oneshot,
  input  logic         up,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] q,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         cnt_ld,
  output logic [W-1:0] ld_val,
  output logic         busy,
  output logic         done,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_nx_s;
  logic [PW-1:0] presc_r, presc_nx_s;
  logic          up_r, oneshot_r;
  logic [W-1:0]  limit_r;
  logic [W-1:0]  term_s, sv_s;
  logic          tick_s, capture_s;

  // Next-state, prescaler and output decode from registered state plus fed-back q
  always_comb begin
    term_s     = up_r ? limit_r : {W{1'b0}};
    sv_s       = up_r ? {W{1'b0}} : limit_r;
    tick_s     = (presc_r == PW'(PRESC - 1));
    capture_s  = 1'b0;
    state_nx_s = state_r;
    presc_nx_s = presc_r;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    cnt_ld     = 1'b0;
    ld_val     = {W{1'b0}};
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      S_IDLE: begin
        presc_nx_s = {PW{1'b0}};
        if (stop) begin
          state_nx_s = S_IDLE;
        end else if (start) begin
          capture_s  = 1'b1;
          state_nx_s = S_LOAD;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_ld     = 1'b1;
        ld_val     = sv_s;
        busy       = 1'b1;
        cnt_up     = up_r;
        presc_nx_s = {PW{1'b0}};
        state_nx_s = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        cnt_up     = up_r;
        cnt_en     = tick_s && (q != term_s);
        presc_nx_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
        // stop outranks terminal count, which outranks hold
        if (stop) begin
          state_nx_s = S_IDLE;
        end else if (tick_s && (q == term_s)) begin
          state_nx_s = oneshot_r ? S_DONE : S_LOAD;
        end else if (hold) begin
          state_nx_s = S_PAUSE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_PAUSE: begin
        busy   = 1'b1;
        cnt_up = up_r;
        if (stop) begin
          state_nx_s = S_IDLE;
        end else if (hold) begin
          state_nx_s = S_PAUSE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
        presc_nx_s = {PW{1'b0}};
      end
    endcase
    state = state_r;
  end

  // State, prescaler and run-configuration registers
  always_ff @(posedge clk) begin
    if (!rs) begin
      state_r   <= S_IDLE;
      presc_r   <= {PW{1'b0}};
      up_r      <= 1'b0;
      limit_r   <= {W{1'b0}};
      oneshot_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      presc_r <= presc_nx_s;
      if (capture_s) begin
        up_r      <= up;
        limit_r   <= limit;
        oneshot_r <= oneshot;
      end else begin
        up_r      <= up_r;
        limit_r   <= limit_r;
        oneshot_r <= oneshot_r;
      end
    end
  end

endmodule

// File: tb/tb_dem_controller.sv
// Bench for dem_controller: a counter stand-in, a run-level reference model checked every
// cycle, and directed scenarios with hand-computed pulse timings.
module tb_dem_controller;
  localparam int W = 4;
  localparam int PRESC = 4;

  logic clk = 1'b0;
  logic rs = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, oneshot = 1'b0, up = 1'b0;
  logic [W-1:0] limit = 4'd0, q;
  logic cnt_en, cnt_up, cnt_ld, busy, done;
  logic [W-1:0] ld_val;
  logic [2:0] state;

  int n_pass = 0, n_total = 0;
  int ncyc = 0, base = 0;
  int en_log[$], ld_log[$], done_log[$];

  dem_controller #(.W(W), .PRESC(PRESC), .PW(16)) dut (
    .clk(clk), .rs(rs), .start(start), .stop(stop), .hold(hold), .oneshot(oneshot),
    .up(up), .limit(limit), .q(q), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_ld(cnt_ld),
    .ld_val(ld_val), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // counter being sequenced, sharing the synchronous reset
  always @(posedge clk) begin
    if (!rs) q <= '0;
    else if (cnt_ld) q <= ld_val;
    else if (cnt_en) q <= cnt_up ? q + 4'd1 : q - 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, ncyc - base, act, exp);
  endtask

  // Reference model: run mode, running-cycle count since last load, and expected count value
  int m_mode = 0, m_ticks = 0;
  logic m_up = 1'b0, m_os = 1'b0;
  logic [W-1:0] m_lim = '0, m_q = '0;
  logic [W-1:0] m_term, m_sv;
  logic m_tick, m_en, m_at_term;

  always @(posedge clk) begin
    ncyc++;
    if (!rs) begin
      m_mode = 0; m_ticks = 0; m_up = 1'b0; m_os = 1'b0; m_lim = '0; m_q = '0;
    end else begin
      m_term    = m_up ? m_lim : 4'd0;
      m_sv      = m_up ? 4'd0 : m_lim;
      m_tick    = (m_mode == 2) && ((m_ticks % PRESC) == PRESC - 1);
      m_at_term = (m_q == m_term);
      m_en      = m_tick && !m_at_term;
      if (m_mode == 1) m_q = m_sv;
      else if (m_en) m_q = m_up ? m_q + 4'd1 : m_q - 4'd1;
      case (m_mode)
        0: if (!stop && start) begin m_up = up; m_lim = limit; m_os = oneshot; m_mode = 1; end
        1: if (stop) m_mode = 0; else begin m_mode = 2; m_ticks = 0; end
        2: if (stop) m_mode = 0;
           else if (m_tick && m_at_term) m_mode = m_os ? 4 : 1;
           else begin m_ticks++; if (hold) m_mode = 3; end
        3: if (stop) m_mode = 0; else if (!hold) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e_term, e_sv;
    logic e_en, e_act;
    e_term = m_up ? m_lim : 4'd0;
    e_sv   = m_up ? 4'd0 : m_lim;
    e_act  = (m_mode >= 1) && (m_mode <= 3);
    e_en   = (m_mode == 2) && ((m_ticks % PRESC) == PRESC - 1) && (m_q != e_term);
    chk("outputs", int'({state, cnt_en, cnt_up, cnt_ld, ld_val, busy, done}),
        int'({3'(m_mode), e_en, e_act & m_up, m_mode == 1, (m_mode == 1) ? e_sv : 4'd0,
              e_act, m_mode == 4}));
    chk("q", int'(q), int'(m_q));
    if (cnt_en) en_log.push_back(ncyc - base);
    if (cnt_ld) ld_log.push_back(ncyc - base);
    if (done)   done_log.push_back(ncyc - base);
  end

  task automatic wait_to(input int rel);
    while (ncyc - base < rel) @(negedge clk);
  endtask

  task automatic begin_run(input logic u, input logic [W-1:0] lim, input logic os);
    @(negedge clk);
    base = ncyc;
    en_log.delete(); ld_log.delete(); done_log.delete();
    start = 1'b1; up = u; limit = lim; oneshot = os;
    @(negedge clk);
    start = 1'b0; up = 1'b0; limit = 4'd0; oneshot = 1'b0;
  endtask

  task automatic chk_log(input string name, input int act[$], input int exp[$]);
    chk({name, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, act[i], exp[i]);
  endtask

  initial begin
    // 1: reset dominates start
    start = 1'b1; up = 1'b1; limit = 4'd5;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_outs", {cnt_en, cnt_ld, busy, done}, 0);
    rs = 1'b1; start = 1'b0; up = 1'b0; limit = 4'd0;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", {state, busy, cnt_ld}, 0);

    // 2: one-shot up count to 3
    begin_run(1'b1, 4'd3, 1'b1);
    wait_to(19);
    chk("s2_idle19", {state, busy}, 0);
    wait_to(21);
    chk_log("s2_ld", ld_log, '{1});
    chk_log("s2_en", en_log, '{5, 9, 13});
    chk_log("s2_done", done_log, '{18});

    // 3: continuous down count from 2, reload every 13 cycles
    begin_run(1'b0, 4'd2, 1'b0);
    wait_to(1);
    chk("s3_ldval", ld_val, 2);
    wait_to(45);
    chk_log("s3_ld", ld_log, '{1, 14, 27, 40});
    chk("s3_period", ld_log[2] - ld_log[1], 13);
    chk_log("s3_en", en_log, '{5, 9, 18, 22, 31, 35, 44});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s3_stop", {state, busy}, 0);

    // 4: hold for 10 cycles shifts later pulses by 10
    begin_run(1'b1, 4'd3, 1'b1);
    wait_to(7);
    hold = 1'b1;
    wait_to(8);
    chk("s4_pause", state, 3);
    wait_to(17);
    hold = 1'b0;
    wait_to(30);
    chk_log("s4_en", en_log, '{5, 19, 23});
    chk_log("s4_done", done_log, '{28});

    // 5: stop during pause; stop beats start in idle
    begin_run(1'b1, 4'd3, 1'b1);
    wait_to(6);
    hold = 1'b1;
    wait_to(8);
    chk("s5_paused", state, 3);
    stop = 1'b1;
    wait_to(9);
    chk("s5_stopped", {state, busy}, 0);
    stop = 1'b0; hold = 1'b0;
    wait_to(14);
    chk("s5_no_done", done_log.size(), 0);
    @(negedge clk);
    base = ncyc; ld_log.delete();
    stop = 1'b1; start = 1'b1; up = 1'b1; limit = 4'd3;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("s5_stop_start", {state, busy}, 0);
    wait_to(4);
    chk("s5_no_ld", ld_log.size(), 0);

    // 6: reset mid-run at q=2, then a clean limit=1 run
    begin_run(1'b1, 4'd5, 1'b1);
    wait_to(10);
    chk("s6_q2", q, 2);
    rs = 1'b0;
    wait_to(11);
    rs = 1'b1;
    chk("s6_rst", {state, cnt_en, cnt_up, cnt_ld, ld_val, busy, done}, 0);
    begin_run(1'b1, 4'd1, 1'b1);
    wait_to(12);
    chk_log("s6_ld", ld_log, '{1});
    chk_log("s6_en", en_log, '{5});
    chk_log("s6_done", done_log, '{10});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
